rand_delay_timer: RTL and testbench
===================================

RAND_DELAY_TIMER -- requirements
Module: rand_delay_timer

Interface
REQ-001 Parameter B, default 6: width of the pseudo-random input word, minimum 4.
REQ-002 Parameter PRESCALE, default 50000: clock cycles per delay tick, minimum 1.
REQ-003 Parameter MIN_TICKS, default 4: fixed delay offset in ticks, range 1..2^B-1.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 lfsr_value  input  B  free-running pseudo-random word from the upstream LFSR.
REQ-007 start  input  1  level-sampled request to begin one random delay.
REQ-008 cancel  input  1  abort the delay in progress.
REQ-009 busy  output  1  high while a delay is in progress or completing.
REQ-010 done  output  1  single-cycle completion pulse.
REQ-011 delay_ticks  output  B+1  delay captured for the current or most recent run.
REQ-012 remaining  output  B+1  ticks left in the current run.

Function
REQ-013 The FSM SHALL have three states: IDLE, COUNT and DONE.
REQ-014 IDLE: start=1 and cancel=0 at an edge SHALL latch delay_ticks = MIN_TICKS + lfsr_value, zero-extended to B+1 bits with no overflow possible, load remaining with the same value, clear the prescaler and enter COUNT.
REQ-015 IDLE with start=1 and cancel=1 in the same cycle SHALL stay in IDLE; cancel wins.
REQ-016 COUNT: the prescaler SHALL count 0..PRESCALE-1 and wrap to 0; each wrap is one tick, and each tick SHALL decrement remaining by 1.
REQ-017 A wrap with remaining==1 SHALL set remaining to 0 and enter DONE.
REQ-018 done SHALL rise exactly delay_ticks*PRESCALE clock edges after the edge that accepted start, and SHALL stay high for exactly one cycle.
REQ-019 DONE SHALL return to IDLE on the next edge unconditionally.
REQ-020 busy SHALL be 1 in COUNT and DONE, and 0 in IDLE.
REQ-021 start SHALL be ignored in COUNT and DONE; it is not queued.
REQ-022 cancel=1 in COUNT SHALL force IDLE on the next edge, with no done pulse; remaining SHALL hold its last value.
REQ-023 cancel=1 on the edge where COUNT would enter DONE SHALL take precedence; no done pulse occurs.
REQ-024 cancel in DONE SHALL have no effect; the done pulse still completes.
REQ-025 delay_ticks SHALL hold its value until the next accepted start.
REQ-026 lfsr_value SHALL be sampled only on the accepting edge; later changes have no effect on the run.
REQ-027 With PRESCALE=1, every COUNT cycle SHALL be a tick.

Reset
REQ-028 Assertion of reset_n=0 SHALL immediately force IDLE, busy=0, done=0, delay_ticks=0, remaining=0 and prescaler=0, regardless of the clock.
REQ-029 Reset asserted mid-COUNT or in DONE SHALL abort the run with no done pulse.
REQ-030 After deassertion, start SHALL be accepted from the first rising edge.

Structure
REQ-031 Package rand_delay_pkg SHALL hold the state enum type (IDLE, COUNT, DONE) and a width helper that returns the prescaler width, $clog2(PRESCALE) with a minimum of 1.
REQ-032 The prescaler SHALL be a sub-module, tick_prescaler (clk, reset_n, clear, enable -> tick), producing a one-cycle tick on each wrap.
REQ-033 All outputs SHALL be registered.
REQ-034 The block SHALL contain no combinational path from any input to any output.

Verification
REQ-035 B=6, PRESCALE=4, MIN_TICKS=2; lfsr_value=5, start pulse -> delay_ticks=7, busy=1 next cycle, done pulse 28 edges after the accepting edge, then busy=0.
REQ-036 Same parameters, lfsr_value=63 -> delay_ticks=65 (no wrap in 7 bits), done after 260 edges.
REQ-037 Start held high for the entire run -> exactly one done pulse; a new run is accepted on the edge after DONE (IDLE), and none is accepted earlier.
REQ-038 Cancel asserted at edge 10 of a 7-tick run -> IDLE on the next edge, done never pulses, remaining=5.
REQ-039 reset_n pulled low asynchronously mid-COUNT -> all outputs 0 before the next edge; no done pulse after release.
REQ-040 start and cancel high together in IDLE -> no run started, busy stays 0.

Source files
------------

// File: rtl/rand_delay_pkg.sv
// Shared types and helpers for the random-delay timer.
// Holds the FSM state encoding and the prescaler width calculation.
package rand_delay_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_e;

  // A PRESCALE of 1 still needs a 1-bit counter to stay legal.
  function automatic int unsigned prescale_width(input int unsigned p);
    return (p < 2) ? 1 : $clog2(p);
  endfunction

endpackage

// File: rtl/rand_delay_timer_prescaler.sv
// Tick prescaler: counts 0..PRESCALE-1 while enabled and flags each wrap.
// The tick is high during the cycle whose closing edge performs the wrap.
module tick_prescaler
  import rand_delay_pkg::*;
#(
  parameter int PRESCALE = 50000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int W = prescale_width(PRESCALE);
  localparam logic [W-1:0] LAST = W'(PRESCALE - 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = enable && !clear && (cnt_q == LAST);

endmodule

// File: rtl/rand_delay_timer.sv
// Random-delay timer: on start, waits (MIN_TICKS + lfsr_value) prescaled ticks
// and then emits a one-cycle done pulse. All outputs come straight from flops.
module rand_delay_timer
  import rand_delay_pkg::*;
#(
  parameter int B         = 6,
  parameter int PRESCALE  = 50000,
  parameter int MIN_TICKS = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [B-1:0] lfsr_value,
  input  logic         start,
  input  logic         cancel,
  output logic         busy,
  output logic         done,
  output logic [B:0]   delay_ticks,
  output logic [B:0]   remaining
);

  localparam logic [B:0] MIN_T = MIN_TICKS[B:0];
  localparam logic [B:0] ONE   = {{B{1'b0}}, 1'b1};

  state_e     state_q, state_d;
  logic [B:0] delay_q, delay_d;
  logic [B:0] rem_q, rem_d;
  logic       busy_q, done_q;
  logic       tick;

  tick_prescaler #(
    .PRESCALE(PRESCALE)
  ) u_prescaler (
    .clk    (clk),
    .reset_n(reset_n),
    .clear  (state_q != COUNT),
    .enable (state_q == COUNT),
    .tick   (tick)
  );

  always_comb begin
    state_d = state_q;
    delay_d = delay_q;
    rem_d   = rem_q;
    case (state_q)
      IDLE: begin
        if (start && !cancel) begin
          // B+1 bits always hold MIN_TICKS + lfsr_value without overflow.
          delay_d = MIN_T + {1'b0, lfsr_value};
          rem_d   = MIN_T + {1'b0, lfsr_value};
          state_d = COUNT;
        end
      end
      COUNT: begin
        if (cancel) begin
          state_d = IDLE;
        end else if (tick) begin
          rem_d = rem_q - ONE;
          if (rem_q == ONE) begin
            state_d = DONE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      delay_q <= '0;
      rem_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      delay_q <= delay_d;
      rem_q   <= rem_d;
      busy_q  <= (state_d != IDLE);
      done_q  <= (state_d == DONE);
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign delay_ticks = delay_q;
  assign remaining   = rem_q;

endmodule

// File: tb/tb_rand_delay_timer.sv
// Directed bench for rand_delay_timer with B=6, PRESCALE=4, MIN_TICKS=2.
// Expected runs are queued when start is driven and retired on each done pulse.
module tb_rand_delay_timer;

  localparam int B  = 6;
  localparam int P  = 4;
  localparam int MT = 2;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [B-1:0] lfsr_value;
  logic         start;
  logic         cancel;
  logic         busy;
  logic         done;
  logic [B:0]   delay_ticks;
  logic [B:0]   remaining;

  typedef struct {
    int delay;
    int edges;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  rand_delay_timer #(
    .B(B), .PRESCALE(P), .MIN_TICKS(MT)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .lfsr_value (lfsr_value),
    .start      (start),
    .cancel     (cancel),
    .busy       (busy),
    .done       (done),
    .delay_ticks(delay_ticks),
    .remaining  (remaining)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_run(input int lfsr);
    exp_t e;
    e.delay = MT + lfsr;
    e.edges = (MT + lfsr) * P;
    sb.push_back(e);
  endtask

  // Call right after the accepting edge; counts edges until done rises.
  task automatic expect_done(input string tag);
    int   edges;
    exp_t e;
    edges = 0;
    while (done !== 1'b1 && edges < 2000) begin
      step();
      edges++;
    end
    e.delay = -1;
    e.edges = -1;
    if (sb.size() > 0) e = sb.pop_front();
    check({tag, "_edges"}, edges, e.edges);
    check({tag, "_delay"}, int'(delay_ticks), e.delay);
    check({tag, "_rem0"}, int'(remaining), 0);
    check({tag, "_busy_in_done"}, int'(busy), 1);
    step();
    check({tag, "_done_width"}, int'(done), 0);
    check({tag, "_busy_after"}, int'(busy), 0);
  endtask

  task automatic count_done(input int n, output int pulses);
    pulses = 0;
    for (int i = 0; i < n; i++) begin
      step();
      if (done === 1'b1) pulses++;
    end
  endtask

  initial begin
    int pulses;
    reset_n    = 1'b0;
    lfsr_value = '0;
    start      = 1'b0;
    cancel     = 1'b0;
    step();
    step();
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_delay", int'(delay_ticks), 0);
    check("rst_rem", int'(remaining), 0);
    reset_n = 1'b1;

    // Basic run: 5 -> 7 ticks, lfsr changes after acceptance are ignored.
    lfsr_value = 6'd5;
    start      = 1'b1;
    push_run(5);
    step();
    start      = 1'b0;
    lfsr_value = 6'd20;
    check("r1_busy", int'(busy), 1);
    check("r1_delay", int'(delay_ticks), 7);
    check("r1_rem", int'(remaining), 7);
    expect_done("r1");
    check("r1_delay_hold", int'(delay_ticks), 7);

    // Maximum lfsr: 65 ticks, needs the extra output bit.
    lfsr_value = 6'd63;
    start      = 1'b1;
    push_run(63);
    step();
    start = 1'b0;
    check("r2_delay", int'(delay_ticks), 65);
    expect_done("r2");

    // Start held through the run: no re-accept in COUNT or DONE.
    lfsr_value = 6'd1;
    start      = 1'b1;
    push_run(1);
    step();
    expect_done("r3");
    lfsr_value = 6'd2;
    push_run(2);
    step();
    start = 1'b0;
    check("r4_busy", int'(busy), 1);
    check("r4_delay", int'(delay_ticks), 4);
    expect_done("r4");

    // Cancel at edge 10 of a 7-tick run.
    lfsr_value = 6'd5;
    start      = 1'b1;
    step();
    start = 1'b0;
    for (int i = 1; i < 10; i++) step();
    cancel = 1'b1;
    step();
    cancel = 1'b0;
    check("cx_busy", int'(busy), 0);
    check("cx_rem", int'(remaining), 5);
    check("cx_delay", int'(delay_ticks), 7);
    count_done(40, pulses);
    check("cx_no_done", pulses, 0);

    // Cancel on the edge that would enter DONE.
    lfsr_value = 6'd0;
    start      = 1'b1;
    step();
    start = 1'b0;
    for (int i = 1; i < 8; i++) step();
    check("cd_rem_before", int'(remaining), 1);
    cancel = 1'b1;
    step();
    cancel = 1'b0;
    check("cd_done", int'(done), 0);
    check("cd_busy", int'(busy), 0);
    check("cd_rem", int'(remaining), 1);
    count_done(10, pulses);
    check("cd_no_done", pulses, 0);

    // Start and cancel together in IDLE.
    start  = 1'b1;
    cancel = 1'b1;
    step();
    check("sc_busy1", int'(busy), 0);
    step();
    check("sc_busy2", int'(busy), 0);
    start  = 1'b0;
    cancel = 1'b0;

    // Asynchronous reset mid-COUNT.
    lfsr_value = 6'd5;
    start      = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 6; i++) step();
    check("ar_busy_pre", int'(busy), 1);
    #2 reset_n = 1'b0;
    #1;
    check("ar_busy", int'(busy), 0);
    check("ar_done", int'(done), 0);
    check("ar_delay", int'(delay_ticks), 0);
    check("ar_rem", int'(remaining), 0);
    step();
    reset_n = 1'b1;
    count_done(40, pulses);
    check("ar_no_done", pulses, 0);
    check("ar_idle", int'(busy), 0);

    // Start accepted on the first edge after reset release.
    reset_n = 1'b0;
    #2;
    reset_n    = 1'b1;
    lfsr_value = 6'd3;
    start      = 1'b1;
    push_run(3);
    step();
    start = 1'b0;
    check("rr_busy", int'(busy), 1);
    expect_done("rr");

    check("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
